// File: rtl/mem_bus_fabric.sv
// PicoRV32 native-bus fabric: registered address decode to N slaves, per-access
// timeout, error response for unmapped/hung accesses and a sticky fault record.
module mem_bus_fabric #(
   parameter int                         NUM_SLAVES     = 3,
   parameter logic [NUM_SLAVES*32-1:0]   ADDR_BASES     = {32'h8000_0100, 32'h8000_0000, 32'h0000_0000},
   parameter logic [NUM_SLAVES*32-1:0]   ADDR_MASKS     = {32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'hFFFF_E000},
   parameter int                         TIMEOUT_CYCLES = 255,
   parameter logic [31:0]                ERR_RDATA      = 32'hDEAD_BEEF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         mem_valid,
   input  logic [31:0]                  mem_addr,
   input  logic [31:0]                  mem_wdata,
   input  logic [3:0]                   mem_wstrb,
   output logic                         mem_ready,
   output logic [31:0]                  mem_rdata,
   output logic [NUM_SLAVES-1:0]        s_select,
   output logic [31:0]                  s_addr,
   output logic [31:0]                  s_wdata,
   output logic [3:0]                   s_wstrb,
   input  logic [NUM_SLAVES-1:0]        s_ready,
   input  logic [NUM_SLAVES*32-1:0]     s_rdata,
   input  logic                         fault_clear,
   output logic                         fault_valid,
   output logic [1:0]                   fault_code,
   output logic [31:0]                  fault_addr,
   output logic                         fault_write,
   output logic [7:0]                   fault_count
);

   localparam int IW      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CW-1:0] TO_LAST_C = CW'(TO_LAST);

   localparam logic [1:0] CODE_UNMAPPED = 2'b01;
   localparam logic [1:0] CODE_TIMEOUT  = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2,
      ERR    = 2'd3
   } state_t;

   state_t                  state_reg, state_next;
   logic [NUM_SLAVES-1:0]   match;
   logic                    hit;
   logic [IW-1:0]           hit_idx;
   logic [IW-1:0]           idx_reg;
   logic [NUM_SLAVES-1:0]   sel_reg;
   logic [31:0]             addr_reg, wdata_reg, rdata_reg;
   logic [3:0]              wstrb_reg;
   logic [CW-1:0]           cnt_reg;
   logic [1:0]              err_code_reg;
   logic                    sel_ready;
   logic [31:0]             sel_rdata;
   logic                    timeout_hit;

   logic                    fault_valid_reg;
   logic [1:0]              fault_code_reg;
   logic [31:0]             fault_addr_reg;
   logic                    fault_write_reg;
   logic [7:0]              fault_count_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_decode
         assign match[gi] = (mem_addr & ADDR_MASKS[32*gi +: 32]) == ADDR_BASES[32*gi +: 32];
      end
   endgenerate

   // Scan downwards so the lowest matching index is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if (match[i]) begin
            hit     = 1'b1;
            hit_idx = IW'(i);
         end
      end
   end

   assign sel_ready   = s_ready[idx_reg];
   assign sel_rdata   = s_rdata[32*int'(idx_reg) +: 32];
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_reg == TO_LAST_C) && !sel_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      mem_ready  = 1'b0;
      mem_rdata  = 32'h0;
      case (state_reg)
         IDLE: begin
            if (mem_valid) state_next = hit ? ACCESS : ERR;
         end
         ACCESS: begin
            if (sel_ready)        state_next = RESP;
            else if (timeout_hit) state_next = ERR;
         end
         RESP: begin
            mem_ready  = 1'b1;
            mem_rdata  = rdata_reg;
            state_next = IDLE;
         end
         ERR: begin
            mem_ready  = 1'b1;
            mem_rdata  = ERR_RDATA;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_reg      <= '0;
         sel_reg      <= '0;
         addr_reg     <= 32'h0;
         wdata_reg    <= 32'h0;
         wstrb_reg    <= 4'h0;
         rdata_reg    <= 32'h0;
         cnt_reg      <= '0;
         err_code_reg <= 2'b00;
      end else begin
         case (state_reg)
            IDLE: begin
               if (mem_valid) begin
                  addr_reg     <= mem_addr;
                  wdata_reg    <= mem_wdata;
                  wstrb_reg    <= mem_wstrb;
                  idx_reg      <= hit_idx;
                  sel_reg      <= hit ? (NUM_SLAVES'(1) << hit_idx) : '0;
                  cnt_reg      <= '0;
                  err_code_reg <= CODE_UNMAPPED;
               end
            end
            ACCESS: begin
               if (sel_ready) begin
                  rdata_reg <= sel_rdata;
                  sel_reg   <= '0;
               end else if (timeout_hit) begin
                  sel_reg      <= '0;
                  err_code_reg <= CODE_TIMEOUT;
               end else if (TIMEOUT_CYCLES != 0) begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // The record commits at the end of the ERR cycle, so a coincident clear loses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fault_valid_reg <= 1'b0;
         fault_code_reg  <= 2'b00;
         fault_addr_reg  <= 32'h0;
         fault_write_reg <= 1'b0;
         fault_count_reg <= 8'h0;
      end else if (state_reg == ERR) begin
         fault_valid_reg <= 1'b1;
         fault_code_reg  <= err_code_reg;
         fault_addr_reg  <= addr_reg;
         fault_write_reg <= (wstrb_reg != 4'h0);
         if (fault_clear)                  fault_count_reg <= 8'd1;
         else if (fault_count_reg != 8'hFF) fault_count_reg <= fault_count_reg + 8'd1;
      end else if (fault_clear) begin
         fault_valid_reg <= 1'b0;
         fault_code_reg  <= 2'b00;
         fault_count_reg <= 8'h0;
      end
   end

   assign s_select    = sel_reg;
   assign s_addr      = addr_reg;
   assign s_wdata     = wdata_reg;
   assign s_wstrb     = wstrb_reg;
   assign fault_valid = fault_valid_reg;
   assign fault_code  = fault_code_reg;
   assign fault_addr  = fault_addr_reg;
   assign fault_write = fault_write_reg;
   assign fault_count = fault_count_reg;

endmodule

// File: tb/tb_mem_bus_fabric.sv
// Scoreboard bench for mem_bus_fabric: behavioural slaves with programmable
// ready latency, expected read data queued at issue and checked at mem_ready.
module tb_mem_bus_fabric;

   localparam int NS = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          mem_valid;
   logic [31:0]   mem_addr, mem_wdata;
   logic [3:0]    mem_wstrb;
   logic          mem_ready;
   logic [31:0]   mem_rdata;
   logic [NS-1:0] s_select;
   logic [31:0]   s_addr, s_wdata;
   logic [3:0]    s_wstrb;
   logic [NS-1:0] s_ready;
   logic [NS*32-1:0] s_rdata;
   logic          fault_clear;
   logic          fault_valid;
   logic [1:0]    fault_code;
   logic [31:0]   fault_addr;
   logic          fault_write;
   logic [7:0]    fault_count;

   logic [31:0]   slave_data [NS];
   int            slave_lat;
   int            sel_cnt;
   logic [NS-1:0] noise_vec;
   logic          rdy;

   int n_checks = 0;
   int n_err    = 0;
   logic [31:0] sb_q [$];

   logic        m_valid;
   logic [1:0]  m_code;
   logic [31:0] m_addr;
   logic        m_write;
   int          m_count;

   mem_bus_fabric #(.NUM_SLAVES(NS), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset(reset),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .s_select(s_select), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_ready(s_ready), .s_rdata(s_rdata),
      .fault_clear(fault_clear), .fault_valid(fault_valid), .fault_code(fault_code),
      .fault_addr(fault_addr), .fault_write(fault_write), .fault_count(fault_count)
   );

   always #5 clk = ~clk;

   // Slave model: ready in select cycle slave_lat (1-based), 0 = never ready.
   always @(posedge clk) begin
      if (s_select == '0) sel_cnt <= 0;
      else                sel_cnt <= sel_cnt + 1;
   end
   assign rdy     = (slave_lat != 0) && (sel_cnt == slave_lat - 1);
   assign s_ready = (s_select & {NS{rdy}}) | (~s_select & noise_vec);
   assign s_rdata = {slave_data[2], slave_data[1], slave_data[0]};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_faults(input string tag);
      check({tag, ".fault_valid"}, 32'(fault_valid), 32'(m_valid));
      check({tag, ".fault_code"},  32'(fault_code),  32'(m_code));
      check({tag, ".fault_addr"},  fault_addr,       m_addr);
      check({tag, ".fault_write"}, 32'(fault_write), 32'(m_write));
      check({tag, ".fault_count"}, 32'(fault_count), 32'(m_count));
   endtask

   task automatic run_access(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, input int lat, input logic [NS-1:0] noise,
                             input logic [NS-1:0] exp_sel, input logic [31:0] exp_rdata,
                             input int exp_cyc, input int exp_sel_cyc, input logic [1:0] exp_err,
                             input bit clr, input bit verbose);
      int cyc, sel_cyc;
      bit done;
      logic [31:0] want;
      @(negedge clk);
      mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
      slave_lat = lat;  noise_vec = noise;
      sb_q.push_back(exp_rdata);
      cyc = 0; sel_cyc = 0; done = 0;
      while (!done && cyc < 50) begin
         @(negedge clk);
         cyc++;
         if (s_select != '0) begin
            if (sel_cyc == 0) begin
               check({name, ".s_select"}, 32'(s_select), 32'(exp_sel));
               check({name, ".s_addr"},   s_addr,        addr);
               check({name, ".s_wdata"},  s_wdata,       wdata);
               check({name, ".s_wstrb"},  32'(s_wstrb),  32'(wstrb));
            end
            sel_cyc++;
         end
         if (mem_ready) begin
            want = sb_q.pop_front();
            check({name, ".mem_rdata"}, mem_rdata, want);
            check({name, ".latency"}, 32'(cyc), 32'(exp_cyc));
            check({name, ".sel_cycles"}, 32'(sel_cyc), 32'(exp_sel_cyc));
            mem_valid   = 1'b0;
            fault_clear = clr;
            done = 1;
         end
      end
      if (!done) begin
         want = sb_q.pop_front();
         check({name, ".no_ready"}, 32'(cyc), 32'(exp_cyc));
         mem_valid = 1'b0;
      end
      @(negedge clk);
      fault_clear = 1'b0;
      noise_vec   = '0;
      if (exp_err != 2'b00) begin
         m_valid = 1'b1;
         m_code  = exp_err;
         m_addr  = addr;
         m_write = (wstrb != 4'h0);
         m_count = clr ? 1 : ((m_count < 255) ? m_count + 1 : 255);
      end
      check({name, ".idle_ready"}, 32'(mem_ready), 32'h0);
      check({name, ".idle_rdata"}, mem_rdata, 32'h0);
      check_faults(name);
      if (verbose)
         $display("txn %s addr=%h wstrb=%h rdata_exp=%h cycles=%0d fault_count=%0d",
                  name, addr, wstrb, exp_rdata, cyc, fault_count);
   endtask

   initial begin
      reset = 1'b1; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
      fault_clear = 1'b0; slave_lat = 0; noise_vec = '0;
      slave_data[0] = 32'h1234_5678; slave_data[1] = 32'hA5A5_0001; slave_data[2] = 32'h0BAD_CAFE;
      m_valid = 1'b0; m_code = 2'b00; m_addr = '0; m_write = 1'b0; m_count = 0;
      repeat (3) @(negedge clk);
      check("rst.mem_ready", 32'(mem_ready), 32'h0);
      check("rst.mem_rdata", mem_rdata, 32'h0);
      check("rst.s_select",  32'(s_select), 32'h0);
      check_faults("rst");
      reset = 1'b0;

      run_access("read_s0",   32'h0000_0010, 32'h0, 4'h0, 2, 3'b000, 3'b001, 32'h1234_5678, 3, 2, 2'b00, 0, 1);
      run_access("write_s1",  32'h8000_0000, 32'h3F, 4'h1, 1, 3'b000, 3'b010, 32'hA5A5_0001, 2, 1, 2'b00, 0, 1);
      run_access("write_s1n", 32'h8000_0000, 32'h3F, 4'h1, 3, 3'b111, 3'b010, 32'hA5A5_0001, 4, 3, 2'b00, 0, 1);
      run_access("unmapped",  32'h4000_0000, 32'h0, 4'h0, 1, 3'b000, 3'b000, 32'hDEAD_BEEF, 1, 0, 2'b01, 0, 1);
      run_access("timeout",   32'h8000_0104, 32'h77, 4'hF, 0, 3'b000, 3'b100, 32'hDEAD_BEEF, 5, 4, 2'b10, 0, 1);
      run_access("ready_last",32'h8000_0104, 32'h78, 4'hF, 4, 3'b000, 3'b100, 32'h0BAD_CAFE, 5, 4, 2'b00, 0, 1);

      // Stand-alone clear: valid/code/count drop, address is kept.
      @(negedge clk); fault_clear = 1'b1;
      @(negedge clk); fault_clear = 1'b0;
      m_valid = 1'b0; m_code = 2'b00; m_count = 0;
      check_faults("clear");

      run_access("clr_vs_err", 32'h4000_0000, 32'h0, 4'h0, 1, 3'b000, 3'b000, 32'hDEAD_BEEF, 1, 0, 2'b01, 1, 1);
      for (int i = 0; i < 300; i++)
         run_access("sat", 32'h5000_0000 + 32'(i * 4), 32'h0, 4'h0, 1, 3'b000, 3'b000,
                    32'hDEAD_BEEF, 1, 0, 2'b01, 0, (i % 50 == 0) || (i >= 252));

      // Reset while the slave is holding the access open.
      @(negedge clk);
      mem_valid = 1'b1; mem_addr = 32'h0000_0020; mem_wdata = 32'h0; mem_wstrb = 4'h0; slave_lat = 0;
      repeat (3) @(negedge clk);
      check("pre_rst.s_select", 32'(s_select), 32'h1);
      reset = 1'b1;
      #1;
      check("mid_rst.s_select",  32'(s_select), 32'h0);
      check("mid_rst.mem_ready", 32'(mem_ready), 32'h0);
      mem_valid = 1'b0;
      @(negedge clk);
      check("mid_rst.mem_ready2", 32'(mem_ready), 32'h0);
      reset = 1'b0;
      m_valid = 1'b0; m_code = 2'b00; m_addr = '0; m_write = 1'b0; m_count = 0;
      check_faults("post_rst");
      $display("txn reset_abort addr=00000020 aborted by reset");
      run_access("after_rst", 32'h0000_0030, 32'h0, 4'h0, 2, 3'b000, 3'b001, 32'h1234_5678, 3, 2, 2'b00, 0, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_bus_fabric.md
Name: mem_bus_fabric

Overview:
- Parametrised PicoRV32 native-memory-bus fabric between the CPU and N memory-mapped slaves (SRAM, LEDs, systick, future peripherals).
- Replaces the ad-hoc combinational decode at SoC top level with:
  - a parametrised address map;
  - registered slave selects;
  - per-access timeout;
  - an error response for unmapped or hung accesses, plus a sticky fault record and interrupt, so the CPU never stalls forever.

Parameters:
- NUM_SLAVES, 3, number of slave ports (1..16).
- ADDR_BASES, {32'h8000_0100, 32'h8000_0000, 32'h0000_0000}, packed NUM_SLAVES*32 bits; slave i base in bits [32i+31:32i].
- ADDR_MASKS, {32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'hFFFF_E000}, packed NUM_SLAVES*32 bits; slave i matches when (mem_addr & MASK_i) == BASE_i.
- TIMEOUT_CYCLES, 255, maximum cycles waiting for s_ready; 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on an error response.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- mem_valid  in  1  CPU request valid.
- mem_addr  in  32  CPU address.
- mem_wdata  in  32  CPU write data.
- mem_wstrb  in  4  CPU byte strobes; 0 means read.
- mem_ready  out  1  transfer complete to CPU.
- mem_rdata  out  32  read data to CPU.
- s_select  out  NUM_SLAVES  one-hot slave select.
- s_addr  out  32  registered copy of mem_addr.
- s_wdata  out  32  registered copy of mem_wdata.
- s_wstrb  out  4  registered copy of mem_wstrb.
- s_ready  in  NUM_SLAVES  per-slave ready.
- s_rdata  in  NUM_SLAVES*32  packed per-slave read data.
- fault_clear  in  1  clears the sticky fault record.
- fault_valid  out  1  sticky: a fault occurred; also the CPU irq source.
- fault_code  out  2  01 = unmapped, 10 = timeout.
- fault_addr  out  32  address of the most recent fault.
- fault_write  out  1  most recent fault was a write (wstrb != 0).
- fault_count  out  8  saturating fault counter.

Behaviour:
- Reset values: all outputs 0, state IDLE, timeout counter 0. Reset mid-transaction aborts it; no mem_ready is issued.
- FSM states: IDLE, ACCESS, RESP, ERR.
- IDLE:
  - On mem_valid, decode mem_addr against all slaves; lowest matching index wins on overlap.
  - Match: register the index and s_addr/s_wdata/s_wstrb, go to ACCESS.
  - No match: go to ERR, fault_code = 01.
- ACCESS:
  - s_select[idx] = 1, all other selects 0; s_* outputs held stable.
  - s_ready of non-selected slaves is ignored.
  - s_ready[idx] = 1: capture s_rdata[idx] and go to RESP.
  - Otherwise, if TIMEOUT_CYCLES != 0, the counter increments. After TIMEOUT_CYCLES consecutive ACCESS cycles without ready, go to ERR with fault_code = 10.
  - s_ready in the same cycle the timeout expires: ready wins, no fault.
- RESP:
  - mem_ready = 1 for exactly one cycle; mem_rdata = captured data; s_select = 0.
  - Then go to IDLE.
- ERR:
  - mem_ready = 1 for exactly one cycle; mem_rdata = ERR_RDATA; s_select = 0. Error writes are dropped.
  - Fault record updated this cycle: fault_valid = 1, fault_code, fault_addr, fault_write; fault_count += 1, saturating at 255.
  - Then go to IDLE.
- Latency: CPU request seen in cycle 0 → s_select high in cycle 1 → s_ready sampled in cycle k ≥ 1 → mem_ready in cycle k+1. Unmapped access: mem_ready in cycle 1.
- mem_ready is low outside RESP/ERR. mem_rdata is 0 when mem_ready is low.
- The master must drop mem_valid after mem_ready (PicoRV32 does). mem_valid deasserting during ACCESS does not abort the access; it completes normally.
- fault_clear:
  - Clears fault_valid, fault_code and fault_count (fault_addr is kept).
  - Clear in the same cycle as a new fault: the new fault wins; fault_count becomes 1.

Test Plan:
- Read 0x0000_0010; slave 0 returns ready 1 cycle after select with rdata 0x1234_5678 → s_select = 001 in cycle 1, mem_ready in cycle 3 with mem_rdata 0x1234_5678.
- Write 0x8000_0000, wdata 0x3F, wstrb 0001 → s_select = 010, s_wdata = 0x3F; mem_ready follows slave ready by 1 cycle; no fault.
- Read unmapped 0x4000_0000 → mem_ready in cycle 1, mem_rdata 0xDEAD_BEEF, fault_valid = 1, fault_code = 01, fault_addr 0x4000_0000, fault_count = 1, no s_select pulse.
- TIMEOUT_CYCLES = 4; write 0x8000_0104 with slave 2 never ready → s_select high for 4 cycles, then mem_ready with fault_code = 10 and fault_write = 1; a ready arriving on the 4th cycle instead completes normally with no fault.
- Assert fault_clear in the same cycle as an unmapped access's ERR → fault_valid stays 1, fault_count = 1. Then 300 unmapped accesses → fault_count saturates at 255.
- Assert reset during ACCESS → s_select and mem_ready drop immediately, FSM returns to IDLE, and the next access completes normally.
